phi_bus_scheduler: RTL and testbench
====================================

PHI_BUS_SCHEDULER -- requirements
Module: phi_bus_scheduler

Interface
REQ-001 The block SHALL have parameter HALF_CYC, default 8, meaning clk cycles per phi half-period; legal range 4..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 2 bits: per-requester request for the next phi-low memory slot; bit 0 is the disk engine, bit 1 is the host port.
REQ-005 The block SHALL have port phi_0, output, 1 bit: registered CPU phase clock.
REQ-006 The block SHALL have port phi_2, output, 1 bit: phi_0 delayed by exactly one clk cycle.
REQ-007 The block SHALL have port cpu_slot, output, 1 bit: high while the bus belongs to the CPU, equal to phi_0.
REQ-008 The block SHALL have port grant, output, 2 bits: one-hot or zero grant for the current phi-low slot.
REQ-009 The block SHALL have port slot_start, output, 1 bit: one-clk pulse on the first cycle of each phi-low phase.
REQ-010 The block SHALL have port stretch, input, 1 bit, only when CLK_STRETCH_EN is defined: request to extend the phi-high phase.

Function
REQ-011 The block SHALL run a two-state FSM, PH_HIGH and PH_LOW, with an 8-bit phase counter cnt counting 0..HALF_CYC-1.
REQ-012 In each state, cnt SHALL increment every clk; when cnt==HALF_CYC-1 it SHALL wrap to 0 and the FSM SHALL toggle state on the same edge.
REQ-013 phi_0 SHALL be 1 in PH_HIGH and 0 in PH_LOW, registered, with a period of 2*HALF_CYC clk and a 50% duty cycle when not stretched.
REQ-014 phi_2 SHALL equal phi_0 delayed by one clk; phi_2 SHALL NOT be combinationally derived.
REQ-015 On the PH_HIGH->PH_LOW edge, the block SHALL sample req and load grant, and grant SHALL be valid in the same cycle that slot_start=1.
REQ-016 Arbitration SHALL work as follows: if exactly one req bit is set, that requester wins; if both are set, the requester not granted in the last non-empty slot wins (round-robin pointer); if neither is set, grant=00 and the pointer is unchanged.
REQ-017 grant SHALL be held constant for the entire PH_LOW phase, and deasserting req mid-phase SHALL NOT revoke it.
REQ-018 grant SHALL clear to 00 on the PH_LOW->PH_HIGH edge and SHALL remain 00 throughout PH_HIGH.
REQ-019 req changes during PH_HIGH SHALL have no effect until the next sampling edge.
REQ-020 grant SHALL never be 11.
REQ-021 cpu_slot and any grant bit SHALL never be high in the same cycle.

Reset
REQ-022 While rst_n=0, the block SHALL force state=PH_LOW, cnt=0, phi_0=0, phi_2=0, cpu_slot=0, grant=00, slot_start=0, and the round-robin pointer to favour bit 0.
REQ-023 After rst_n deasserts, the first HALF_CYC cycles SHALL be a PH_LOW phase with grant=00 and no slot_start, after which the FSM SHALL enter PH_HIGH.
REQ-024 A reset asserted mid-phase SHALL abort the phase immediately, with no completion of the current grant.

Configuration
REQ-025 With macro CLK_STRETCH_EN defined, the stretch port SHALL exist, and stretch=1 sampled while in PH_HIGH with cnt==HALF_CYC-1 SHALL hold cnt and state, so that phi_0 stays high.
REQ-026 With CLK_STRETCH_EN defined, the first cycle sampled with stretch=0 SHALL perform the normal transition; the stretch length is unbounded and the grant pointer is unaffected.
REQ-027 Without CLK_STRETCH_EN, the stretch port and its logic SHALL be absent, and the phase timing SHALL be fixed.

Verification
REQ-028 Free run test: HALF_CYC=8, req=00, 64 cycles after reset -> phi_0 period 16 clk, high 8 / low 8; phi_2 lags by 1 clk; grant always 00.
REQ-029 Single requester test: req=01 held -> every PH_LOW gives grant=01 with slot_start on its first cycle; grant=00 for all of PH_HIGH.
REQ-030 Contention test: req=11 held for 4 phi periods -> grant sequence 01,10,01,10.
REQ-031 Mid-phase drop test: req=10 drops to 00 on the 3rd cycle of PH_LOW -> grant stays 10 until the PH_HIGH edge; the next slot gives 00.
REQ-032 Reset test: rst_n pulled low on cycle 5 of a granted PH_LOW -> all outputs are 0 within the same cycle (async); after release, 8 low cycles pass before the first phi_0 rise.
REQ-033 Stretch test (CLK_STRETCH_EN only): stretch=1 for 5 cycles at the end of PH_HIGH -> phi_0 high for 13 clk; the following PH_LOW is 8 clk and arbitration is unchanged.

Source files
------------

// File: rtl/phi_bus_scheduler.sv
// Phi clock generator with a phi-low memory-slot arbiter for the disk engine (req[0]) and host port (req[1]).
// Optional feature macro: CLK_STRETCH_EN adds the stretch input that extends the phi-high phase.
module phi_bus_scheduler #(
    parameter int HALF_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
`ifdef CLK_STRETCH_EN
    input  logic       stretch,
`endif
    output logic       phi_0,
    output logic       phi_2,
    output logic       cpu_slot,
    output logic [1:0] grant,
    output logic       slot_start
);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    localparam logic [7:0] CNT_LAST = 8'(HALF_CYC - 1);

    phase_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phi_0_q, phi_0_d;
    logic       phi_2_q, phi_2_d;
    logic [1:0] grant_q, grant_d;
    logic       slot_start_q, slot_start_d;
    // rr_ptr_q = 1 means bit 1 wins the next tie; reset favours bit 0.
    logic       rr_ptr_q, rr_ptr_d;

    logic       cnt_last;
    logic       hold;
    logic [1:0] arb_grant;

    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef CLK_STRETCH_EN
    assign hold = stretch && (state_q == PH_HIGH) && cnt_last;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        arb_grant = 2'b00;
        unique case (req)
            2'b01:   arb_grant = 2'b01;
            2'b10:   arb_grant = 2'b10;
            2'b11:   arb_grant = rr_ptr_q ? 2'b10 : 2'b01;
            default: arb_grant = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 8'd1;
        grant_d      = grant_q;
        slot_start_d = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (cnt_last) begin
            cnt_d = 8'd0;
            if (state_q == PH_HIGH) begin
                state_d      = PH_LOW;
                grant_d      = arb_grant;
                slot_start_d = 1'b1;
                // The loser of this slot is favoured next; an empty slot leaves the pointer alone.
                if (arb_grant != 2'b00) begin
                    rr_ptr_d = arb_grant[0];
                end
            end else begin
                state_d = PH_HIGH;
                grant_d = 2'b00;
            end
        end
        phi_0_d = (state_d == PH_HIGH);
        phi_2_d = phi_0_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PH_LOW;
            cnt_q        <= 8'd0;
            phi_0_q      <= 1'b0;
            phi_2_q      <= 1'b0;
            grant_q      <= 2'b00;
            slot_start_q <= 1'b0;
            rr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phi_0_q      <= phi_0_d;
            phi_2_q      <= phi_2_d;
            grant_q      <= grant_d;
            slot_start_q <= slot_start_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign phi_0      = phi_0_q;
    assign phi_2      = phi_2_q;
    assign cpu_slot   = phi_0_q;
    assign grant      = grant_q;
    assign slot_start = slot_start_q;

endmodule

// File: tb/tb_phi_bus_scheduler.sv
// Randomized self-checking bench for phi_bus_scheduler against a time-index reference model.
// Define CLK_STRETCH_EN for both bench and design to exercise the stretch input.
module tb_phi_bus_scheduler;

    localparam int H = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       stretch;
    logic       phi_0;
    logic       phi_2;
    logic       cpu_slot;
    logic [1:0] grant;
    logic       slot_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: t = effective edges since reset release; phase index t/H (even = low), position t%H.
    int         t;
    int         last_win;
    logic       exp_phi0;
    logic       exp_phi2;
    logic       exp_ss;
    logic [1:0] exp_grant;

    phi_bus_scheduler #(.HALF_CYC(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
`ifdef CLK_STRETCH_EN
        .stretch    (stretch),
`endif
        .phi_0      (phi_0),
        .phi_2      (phi_2),
        .cpu_slot   (cpu_slot),
        .grant      (grant),
        .slot_start (slot_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("phi_0", {7'd0, phi_0}, {7'd0, exp_phi0});
        check_eq("phi_2", {7'd0, phi_2}, {7'd0, exp_phi2});
        check_eq("cpu_slot", {7'd0, cpu_slot}, {7'd0, exp_phi0});
        check_eq("grant", {6'd0, grant}, {6'd0, exp_grant});
        check_eq("slot_start", {7'd0, slot_start}, {7'd0, exp_ss});
        check_eq("excl", {7'd0, cpu_slot & (|grant)}, 8'd0);
    endtask

    function automatic logic [1:0] arbitrate(input logic [1:0] r);
        int w;
        w = -1;
        if (r == 2'b01) w = 0;
        else if (r == 2'b10) w = 1;
        else if (r == 2'b11) w = (last_win == 0) ? 1 : 0;
        if (w < 0) return 2'b00;
        last_win = w;
        return (w == 0) ? 2'b01 : 2'b10;
    endfunction

    // Applies req/stretch, advances one clock edge, updates the model and checks at the negedge.
    task automatic step(input logic [1:0] r, input logic s);
        int  p;
        int  pos;
        bit  held;
        req     = r;
        stretch = s;
        p    = t / H;
        pos  = t % H;
        held = 1'b0;
`ifdef CLK_STRETCH_EN
        held = s && (p % 2 == 1) && (pos == H - 1);
`endif
        @(posedge clk);
        if (!held) t++;
        p   = t / H;
        pos = t % H;
        exp_phi2 = exp_phi0;
        exp_phi0 = (p % 2 == 1);
        exp_ss   = !held && (p % 2 == 0) && (pos == 0) && (t > 0);
        if (exp_ss) exp_grant = arbitrate(r);
        if (p % 2 == 1) exp_grant = 2'b00;
        @(negedge clk);
        check_outputs();
        if (slot_start) $display("slot t=%0d req=%b grant=%b", t, r, grant);
    endtask

    task automatic model_reset();
        t         = 0;
        last_win  = 1;
        exp_phi0  = 1'b0;
        exp_phi2  = 1'b0;
        exp_ss    = 1'b0;
        exp_grant = 2'b00;
    endtask

    // Asserts rst_n between clock edges and checks that outputs clear before the next edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    logic [1:0] seq_exp [4];
    logic [1:0] seq_got [$];
    int         high_len;
    int         low_len;
    int         n_str;

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        stretch = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Free run with no requests
        for (int i = 0; i < 64; i++) step(2'b00, 1'b0);

        // Single requester held
        for (int i = 0; i < 64; i++) step(2'b01, 1'b0);

        // Contention from a fresh reset: alternating grants
        do_reset();
        seq_exp[0] = 2'b01; seq_exp[1] = 2'b10; seq_exp[2] = 2'b01; seq_exp[3] = 2'b10;
        for (int i = 0; i < 8 * H; i++) begin
            step(2'b11, 1'b0);
            if (slot_start) seq_got.push_back(grant);
        end
        check_eq("rr_count", 8'(seq_got.size()), 8'd4);
        for (int i = 0; i < 4 && i < seq_got.size(); i++)
            check_eq("rr_seq", {6'd0, seq_got[i]}, {6'd0, seq_exp[i]});

        // Mid-phase drop: req=10 sampled, dropped on the third low cycle
        for (int i = 0; i < 4 * H && (t % (2 * H)) != 2 * H - 1; i++) step(2'b00, 1'b0);
        check_eq("align_drop", 8'(t % (2 * H)), 8'(2 * H - 1));
        step(2'b10, 1'b0);
        check_eq("drop_grant", {6'd0, grant}, 8'd2);
        step(2'b10, 1'b0);
        for (int i = 0; i < 3 * H; i++) step(2'b00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic s;
            s = 1'b0;
`ifdef CLK_STRETCH_EN
            s = ($urandom_range(0, 3) == 0);
`endif
            step(2'($urandom_range(0, 3)), s);
        end

        // Reset on the fifth cycle of a granted low phase
        for (int i = 0; i < 4 * H && (t % (2 * H)) != 2 * H - 1; i++) step(2'b01, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b01, 1'b0);
        check_eq("pre_rst_grant", {6'd0, grant}, 8'd1);
        do_reset();
        low_len = 0;
        for (int i = 0; i < 3 * H && !phi_0; i++) begin
            step(2'b01, 1'b0);
            if (!phi_0) low_len++;
        end
        check_eq("post_rst_low", 8'(low_len + 1), 8'(H));
        for (int i = 0; i < 4 * H; i++) step(2'b11, 1'b0);

`ifdef CLK_STRETCH_EN
        // Stretch the end of one high phase by five cycles
        for (int i = 0; i < 4 * H && (t % (2 * H)) != H - 1; i++) step(2'b11, 1'b0);
        high_len = 0;
        n_str    = 0;
        for (int i = 0; i < 4 * H && (high_len == 0 || phi_0); i++) begin
            logic s;
            s = ((t % (2 * H)) == 2 * H - 1) && (n_str < 5);
            if (s) n_str++;
            step(2'b11, s);
            if (phi_0) high_len++;
        end
        check_eq("stretch_high", 8'(high_len), 8'(H + 5));
        low_len = 1;
        for (int i = 0; i < 4 * H && !phi_0; i++) begin
            step(2'b11, 1'b0);
            if (!phi_0) low_len++;
        end
        check_eq("stretch_low", 8'(low_len), 8'(H));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
